gray_read_arbiter: RTL and testbench

//  Shares the single host grayscale-image read port (gray_addr/gray_req/gray_data)

---
 rtl/gray_read_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_gray_read_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : gray_read_arbiter
// Function : Round-robin sharing of the host grayscale read port between two
//            read engines, with in-order return routing. Define GRAY_ARB_LOCK_EN
//            to let a port hold the grant across a window fetch.
// Revision : 1.0  initial release
// ============================================================================
module gray_read_arbiter #(
    parameter int AW       = 14,
    parameter int DW       = 8,
    parameter int DATA_LAT = 1,
    parameter int MAX_LOCK = 9
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          gray_ready,
    output logic [AW-1:0] gray_addr,
    output logic          gray_req,
    input  logic [DW-1:0] gray_data,
    input  logic          req0,
    input  logic          req1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic          lock0,
    input  logic          lock1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata,
    output logic          busy
);

    localparam logic [1:0] ST_WAIT_RDY = 2'd0;
    localparam logic [1:0] ST_RUN      = 2'd1;
    localparam logic [1:0] ST_DRAIN    = 2'd2;

    logic [1:0]          state_q, state_d;
    logic                last_gnt_q, last_gnt_d;
    logic                issue_port_q, issue_port_d;
    logic                gray_req_q, gray_req_d;
    logic [AW-1:0]       gray_addr_q, gray_addr_d;
    logic                gnt0_q, gnt0_d;
    logic                gnt1_q, gnt1_d;
    logic                rvalid0_q, rvalid0_d;
    logic                rvalid1_q, rvalid1_d;
    logic [DW-1:0]       rdata_q, rdata_d;
    logic [DATA_LAT-1:0] tag_vld_q, tag_vld_d;
    logic [DATA_LAT-1:0] tag_port_q, tag_port_d;

    logic w_hold;
    logic w_win;
    logic w_issue;
    logic w_pipe_empty;
    logic w_ret_vld;
    logic w_ret_port;

`ifdef GRAY_ARB_LOCK_EN
    localparam logic [3:0] LOCK_MAX = 4'(MAX_LOCK);

    logic [3:0] lock_cnt_q, lock_cnt_d;
    logic       w_lock_last;
    logic       w_req_last;
    logic       w_lock_win;

    // The previous owner keeps priority only while its locked run is below the cap.
    always_comb begin
        w_lock_last = last_gnt_q ? lock1 : lock0;
        w_req_last  = last_gnt_q ? req1  : req0;
        w_hold      = w_req_last & w_lock_last & (lock_cnt_q != 4'd0) & (lock_cnt_q < LOCK_MAX);
    end

    always_comb begin
        w_lock_win = w_win ? lock1 : lock0;
        lock_cnt_d = lock_cnt_q;
        if (w_issue) begin
            if (!w_lock_win)
                lock_cnt_d = 4'd0;
            else if (lock_cnt_q == 4'd0)
                lock_cnt_d = 4'd1;
            else if (w_win != last_gnt_q)
                lock_cnt_d = 4'd0;
            else if (lock_cnt_q < LOCK_MAX)
                lock_cnt_d = lock_cnt_q + 4'd1;
        end else if (!w_lock_last) begin
            lock_cnt_d = 4'd0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            lock_cnt_q <= 4'd0;
        else
            lock_cnt_q <= lock_cnt_d;
    end
`else
    logic w_unused_lock;

    assign w_hold        = 1'b0;
    assign w_unused_lock = lock0 | lock1 | (MAX_LOCK == 0);
`endif

    always_comb begin
        w_win        = (req0 & req1) ? (w_hold ? last_gnt_q : ~last_gnt_q) : req1;
        w_issue      = (state_q == ST_RUN) & gray_ready & (req0 | req1);
        w_pipe_empty = ~gray_req_q & ~(|tag_vld_q);
        w_ret_vld    = tag_vld_q[DATA_LAT-1];
        w_ret_port   = tag_port_q[DATA_LAT-1];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_WAIT_RDY: if (gray_ready) state_d = ST_RUN;
            ST_RUN:      if (!gray_ready) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (gray_ready)
                    state_d = ST_RUN;
                else if (w_pipe_empty)
                    state_d = ST_WAIT_RDY;
            end
            default:     state_d = ST_WAIT_RDY;
        endcase
    end

    always_comb begin
        gray_req_d   = w_issue;
        gnt0_d       = w_issue & ~w_win;
        gnt1_d       = w_issue & w_win;
        gray_addr_d  = w_issue ? (w_win ? addr1 : addr0) : gray_addr_q;
        issue_port_d = w_issue ? w_win : issue_port_q;
        last_gnt_d   = w_issue ? w_win : last_gnt_q;
        rvalid0_d    = w_ret_vld & ~w_ret_port;
        rvalid1_d    = w_ret_vld & w_ret_port;
        rdata_d      = w_ret_vld ? gray_data : rdata_q;
    end

    // The issue register is the first tag stage; the pipe adds DATA_LAT more.
    generate
        if (DATA_LAT == 1) begin : g_tag_single
            always_comb begin
                tag_vld_d  = gray_req_q;
                tag_port_d = issue_port_q;
            end
        end else begin : g_tag_shift
            always_comb begin
                tag_vld_d  = {tag_vld_q[DATA_LAT-2:0], gray_req_q};
                tag_port_d = {tag_port_q[DATA_LAT-2:0], issue_port_q};
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_WAIT_RDY;
            last_gnt_q   <= 1'b1;
            issue_port_q <= 1'b0;
            gray_req_q   <= 1'b0;
            gray_addr_q  <= '0;
            gnt0_q       <= 1'b0;
            gnt1_q       <= 1'b0;
            rvalid0_q    <= 1'b0;
            rvalid1_q    <= 1'b0;
            rdata_q      <= '0;
            tag_vld_q    <= '0;
            tag_port_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_gnt_q   <= last_gnt_d;
            issue_port_q <= issue_port_d;
            gray_req_q   <= gray_req_d;
            gray_addr_q  <= gray_addr_d;
            gnt0_q       <= gnt0_d;
            gnt1_q       <= gnt1_d;
            rvalid0_q    <= rvalid0_d;
            rvalid1_q    <= rvalid1_d;
            rdata_q      <= rdata_d;
            tag_vld_q    <= tag_vld_d;
            tag_port_q   <= tag_port_d;
        end
    end

    assign gray_req  = gray_req_q;
    assign gray_addr = gray_addr_q;
    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign rvalid0   = rvalid0_q;
    assign rvalid1   = rvalid1_q;
    assign rdata     = rdata_q;
    assign busy      = gray_req_q | (|tag_vld_q);

endmodule
`default_nettype wire

// File: tb/tb_gray_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_gray_read_arbiter
// Function : Directed scoreboard bench for gray_read_arbiter with a host
//            memory model of DATA_LAT cycles read latency.
// Revision : 1.0  initial release
// ============================================================================
module tb_gray_read_arbiter;

    localparam int AW       = 14;
    localparam int DW       = 8;
    localparam int DATA_LAT = 1;
    localparam int MAX_LOCK = 9;

    logic          clk = 1'b0;
    logic          reset;
    logic          gray_ready;
    logic [AW-1:0] gray_addr;
    logic          gray_req;
    logic [DW-1:0] gray_data;
    logic          req0, req1;
    logic [AW-1:0] addr0, addr1;
    logic          lock0, lock1;
    logic          gnt0, gnt1;
    logic          rvalid0, rvalid1;
    logic [DW-1:0] rdata;
    logic          busy;

    typedef struct {
        logic          port;
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    exp_t sb[$];
    int   gnt_order[$];
    int   exp_order[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc      = 0;
    int   g_total  = 0;
    int   n0       = 0;
    int   n1       = 0;

    always #5 clk = ~clk;

    gray_read_arbiter #(
        .AW       (AW),
        .DW       (DW),
        .DATA_LAT (DATA_LAT),
        .MAX_LOCK (MAX_LOCK)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .gray_ready (gray_ready),
        .gray_addr  (gray_addr),
        .gray_req   (gray_req),
        .gray_data  (gray_data),
        .req0       (req0),
        .req1       (req1),
        .addr0      (addr0),
        .addr1      (addr1),
        .lock0      (lock0),
        .lock1      (lock1),
        .gnt0       (gnt0),
        .gnt1       (gnt1),
        .rvalid0    (rvalid0),
        .rvalid1    (rvalid1),
        .rdata      (rdata),
        .busy       (busy)
    );

    // Image content: 0x0081 maps to 8'h5A.
    function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
        return a[7:0] ^ {2'b00, a[13:8]} ^ 8'hDB;
    endfunction

    logic [DW-1:0] host_pipe [DATA_LAT];

    always @(posedge clk) begin
        host_pipe[0] <= mem_f(gray_addr);
        for (int i = 1; i < DATA_LAT; i++)
            host_pipe[i] <= host_pipe[i-1];
    end

    assign gray_data = host_pipe[DATA_LAT-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample at the falling edge, score grants and returns, and let
    // each engine move to its next address once its grant is seen.
    task automatic step();
        exp_t e;
        @(negedge clk);
        cyc++;
        chk("gnt_excl", 32'(gnt0 & gnt1), 32'd0);
        chk("rvalid_excl", 32'(rvalid0 & rvalid1), 32'd0);
        chk("req_vs_gnt", 32'(gray_req), 32'(gnt0 | gnt1));
        if (gnt0 === 1'b1) begin
            chk("gnt0_addr", 32'(gray_addr), 32'(addr0));
            e.port = 1'b0; e.data = mem_f(addr0); e.cyc = cyc;
            sb.push_back(e);
            gnt_order.push_back(0);
            g_total++;
            n0--;
            if (n0 <= 0) req0 = 1'b0;
            else         addr0 = addr0 + 14'd1;
        end
        if (gnt1 === 1'b1) begin
            chk("gnt1_addr", 32'(gray_addr), 32'(addr1));
            e.port = 1'b1; e.data = mem_f(addr1); e.cyc = cyc;
            sb.push_back(e);
            gnt_order.push_back(1);
            g_total++;
            n1--;
            if (n1 <= 0) req1 = 1'b0;
            else         addr1 = addr1 + 14'd1;
        end
        if (rvalid0 === 1'b1 || rvalid1 === 1'b1) begin
            chk("rvalid_expected", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("rvalid_port", 32'(rvalid1), 32'(e.port));
                chk("rdata", 32'(rdata), 32'(e.data));
                chk("latency", 32'(cyc - e.cyc), 32'(DATA_LAT + 1));
            end
        end
    endtask

    task automatic run_until_idle(input string tag, input int budget);
        int i;
        i = 0;
        while (!(n0 <= 0 && n1 <= 0 && sb.size() == 0 && busy === 1'b0) && i < budget) begin
            step();
            i++;
        end
        chk(tag, 32'(i < budget), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int k;

        reset = 1'b0; gray_ready = 1'b0;
        req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0; lock0 = 1'b0; lock1 = 1'b0;
        #1;
        chk("rst_gray_req", 32'(gray_req), 32'd0);
        chk("rst_gray_addr", 32'(gray_addr), 32'd0);
        chk("rst_gnt", 32'({gnt1, gnt0}), 32'd0);
        chk("rst_rvalid", 32'({rvalid1, rvalid0}), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        @(negedge clk);
        reset = 1'b1; gray_ready = 1'b1;
        step();

        // Single read
        req0 = 1'b1; addr0 = 14'h0081; n0 = 1;
        step();
        chk("t1_gnt0", 32'(gnt0), 32'd1);
        chk("t1_gray_req", 32'(gray_req), 32'd1);
        chk("t1_gray_addr", 32'(gray_addr), 32'h81);
        step();
        chk("t1_early_rvalid", 32'(rvalid0), 32'd0);
        step();
        chk("t1_rvalid0", 32'(rvalid0), 32'd1);
        chk("t1_rdata", 32'(rdata), 32'h5A);
        step();
        chk("t1_rvalid_pulse", 32'(rvalid0), 32'd0);
        chk("t1_rdata_hold", 32'(rdata), 32'h5A);

        // Fairness: port 0 won last, so the first tie goes to port 1
        gnt_order.delete();
        addr0 = 14'h0100; n0 = 6; req0 = 1'b1;
        addr1 = 14'h2000; n1 = 6; req1 = 1'b1;
        run_until_idle("t2_idle", 60);
        chk("t2_count", 32'(gnt_order.size()), 32'd12);
        for (int i = 0; i < gnt_order.size() && i < 12; i++)
            chk("t2_order", 32'(gnt_order[i]), 32'((i % 2 == 0) ? 1 : 0));

        // Ready drop after three issues
        addr0 = 14'h0300; n0 = 5; req0 = 1'b1;
        addr1 = 14'h1234; n1 = 1; req1 = 1'b1;
        base = g_total; k = 0;
        while (g_total < base + 3 && k < 10) begin step(); k++; end
        chk("t4_three_issued", 32'(g_total - base), 32'd3);
        gray_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("t4_no_req", 32'(gray_req), 32'd0);
        end
        chk("t4_sb_empty", 32'(sb.size()), 32'd0);
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_state", 32'(dut.state_q), 32'd0);
        req0 = 1'b0; n0 = 0; req1 = 1'b0; n1 = 0;

        // Reset with two reads in flight
        gray_ready = 1'b1;
        step();
        addr0 = 14'h0400; n0 = 4; req0 = 1'b1;
        addr1 = 14'h0500; n1 = 4; req1 = 1'b1;
        base = g_total; k = 0;
        while (g_total < base + 2 && k < 10) begin step(); k++; end
        chk("t5_two_issued", 32'(g_total - base), 32'd2);
        chk("t5_busy_before", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        chk("t5_gray_req", 32'(gray_req), 32'd0);
        chk("t5_gray_addr", 32'(gray_addr), 32'd0);
        chk("t5_gnt", 32'({gnt1, gnt0}), 32'd0);
        chk("t5_rvalid", 32'({rvalid1, rvalid0}), 32'd0);
        chk("t5_rdata", 32'(rdata), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        sb.delete();
        req0 = 1'b0; req1 = 1'b0; n0 = 0; n1 = 0;
        step();
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("t5_no_rvalid", 32'(rvalid0 | rvalid1), 32'd0);
        end
        chk("t5_rdata_after", 32'(rdata), 32'd0);

        // Lock stimulus, straight after reset
        gnt_order.delete();
        lock0 = 1'b1;
        addr0 = 14'h0600; n0 = 20; req0 = 1'b1;
        addr1 = 14'h0700; n1 = 3;  req1 = 1'b1;
        run_until_idle("t3_idle", 100);
        lock0 = 1'b0;
        chk("t3_first_tie", 32'((gnt_order.size() > 0) ? gnt_order[0] : -1), 32'd0);
`ifdef GRAY_ARB_LOCK_EN
        for (int i = 0; i < 9; i++) exp_order.push_back(0);
        exp_order.push_back(1);
        for (int i = 0; i < 9; i++) exp_order.push_back(0);
        exp_order.push_back(1);
        exp_order.push_back(0);
        exp_order.push_back(0);
        exp_order.push_back(1);
`else
        for (int i = 0; i < 3; i++) begin
            exp_order.push_back(0);
            exp_order.push_back(1);
        end
        for (int i = 0; i < 17; i++) exp_order.push_back(0);
`endif
        chk("t3_count", 32'(gnt_order.size()), 32'(exp_order.size()));
        for (int i = 0; i < gnt_order.size() && i < exp_order.size(); i++)
            chk("t3_order", 32'(gnt_order[i]), 32'(exp_order[i]));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
